// File: rtl/param_proc_pkg.sv
// param_proc_pkg: opcode and FSM state enums plus flag bit positions
// shared by param_proc_core and its bench.
package param_proc_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_NOT = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9,
        OP_ROR = 4'd10,
        OP_ROL = 4'd11,
        OP_LDI = 4'd12,
        OP_MOV = 4'd13,
        OP_CLR = 4'd14,
        OP_NOP = 4'd15
    } op_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_DIV_RUN = 1'b1
    } state_e;

    localparam int FLAG_Z  = 0;
    localparam int FLAG_C  = 1;
    localparam int FLAG_DZ = 2;
    localparam int NFLAGS  = 3;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle.
// done and quotient reflect the final step, so the caller can write back on that edge.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] step_rem, step_quo;

    always_comb begin
        // One extra bit on the trial subtraction: its MSB is the borrow.
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        step_quo = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        step_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
            cnt_d  = CNT_W'(WIDTH);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = step_rem;
            quo_d  = step_quo;
            cnt_d  = cnt_q - CNT_W'(1);
            busy_d = (cnt_q != CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == CNT_W'(1));
    assign quotient = step_quo;

endmodule

// File: rtl/param_proc_core.sv
// param_proc_core: parametrised register-file ALU processor with iterative divide.
// Optional macro PROC_CORE_ROTN_EN: ROR/ROL rotate by A[$clog2(WIDTH)-1:0] instead of 1.
module param_proc_core #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int SEL_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       instr_op,
    input  logic [SEL_W-1:0] instr_src,
    input  logic [SEL_W-1:0] instr_dst,
    input  logic [WIDTH-1:0] imm_data,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_dz,
    input  logic [SEL_W-1:0] dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);
    import param_proc_pkg::*;

    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   regs_d [NREGS];
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic [NFLAGS-1:0]  flags_q, flags_d;
    logic               res_valid_q, res_valid_d;
    state_e             state_q, state_d;
    logic [SEL_W-1:0]   div_dst_q, div_dst_d;

    op_e                op;
    logic [WIDTH-1:0]   op_a, op_b, alu_res;
    logic               alu_c;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic               div_start, div_busy, div_done;
    logic [WIDTH-1:0]   div_quo;

`ifdef PROC_CORE_ROTN_EN
    localparam int RA_W = $clog2(WIDTH);
    logic [RA_W:0]        rot_raw, rot_amt;
    logic [2*WIDTH-1:0]   rot_dbl_r, rot_dbl_l;
`endif

    assign op   = op_e'(instr_op);
    assign op_a = regs_q[instr_dst];
    assign op_b = regs_q[instr_src];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        sum     = {1'b0, op_a} + {1'b0, op_b};
        diff    = {1'b0, op_a} - {1'b0, op_b};
        prod    = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
`ifdef PROC_CORE_ROTN_EN
        // Fold amounts >= WIDTH back into range for non-power-of-two widths.
        rot_raw   = {1'b0, op_a[RA_W-1:0]};
        rot_amt   = (rot_raw >= (RA_W+1)'(WIDTH)) ? rot_raw - (RA_W+1)'(WIDTH) : rot_raw;
        rot_dbl_r = {op_b, op_b} >> rot_amt;
        rot_dbl_l = {op_b, op_b} << rot_amt;
`endif
        case (op)
            OP_ADD: begin alu_res = sum[WIDTH-1:0];  alu_c = sum[WIDTH];  end
            OP_SUB: begin alu_res = diff[WIDTH-1:0]; alu_c = diff[WIDTH]; end
            OP_MUL: begin alu_res = prod[WIDTH-1:0]; alu_c = |prod[2*WIDTH-1:WIDTH]; end
            OP_DIV: alu_res = '1;
            OP_NOT: alu_res = ~op_a;
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_SHL: begin alu_res = {op_b[WIDTH-2:0], 1'b0}; alu_c = op_b[WIDTH-1]; end
            OP_SHR: begin alu_res = {1'b0, op_b[WIDTH-1:1]}; alu_c = op_b[0]; end
`ifdef PROC_CORE_ROTN_EN
            OP_ROR: begin alu_res = rot_dbl_r[WIDTH-1:0];       alu_c = (rot_amt != '0) && alu_res[WIDTH-1]; end
            OP_ROL: begin alu_res = rot_dbl_l[2*WIDTH-1:WIDTH]; alu_c = (rot_amt != '0) && alu_res[0]; end
`else
            OP_ROR: alu_res = {op_b[0], op_b[WIDTH-1:1]};
            OP_ROL: alu_res = {op_b[WIDTH-2:0], op_b[WIDTH-1]};
`endif
            OP_LDI: alu_res = imm_data;
            OP_MOV: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        regs_d      = regs_q;
        res_data_d  = res_data_q;
        flags_d     = flags_q;
        res_valid_d = 1'b0;
        state_d     = state_q;
        div_dst_d   = div_dst_q;
        div_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (op == OP_DIV && op_b != '0) begin
                        div_start = 1'b1;
                        div_dst_d = instr_dst;
                        state_d   = ST_DIV_RUN;
                    end else if (op != OP_NOP) begin
                        if (op == OP_CLR) regs_d = '{default: '0};
                        else              regs_d[instr_dst] = alu_res;
                        res_data_d       = alu_res;
                        flags_d[FLAG_Z]  = (alu_res == '0);
                        flags_d[FLAG_C]  = alu_c;
                        flags_d[FLAG_DZ] = (op == OP_DIV);
                        res_valid_d      = 1'b1;
                    end
                end
            end
            ST_DIV_RUN: begin
                if (div_done) begin
                    regs_d[div_dst_q] = div_quo;
                    res_data_d        = div_quo;
                    flags_d[FLAG_Z]   = (div_quo == '0);
                    flags_d[FLAG_C]   = 1'b0;
                    flags_d[FLAG_DZ]  = 1'b0;
                    res_valid_d       = 1'b1;
                    state_d           = ST_IDLE;
                end else if (!div_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q      <= '{default: '0};
            res_data_q  <= '0;
            flags_q     <= '0;
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
            div_dst_q   <= '0;
        end else begin
            regs_q      <= regs_d;
            res_data_q  <= res_data_d;
            flags_q     <= flags_d;
            res_valid_q <= res_valid_d;
            state_q     <= state_d;
            div_dst_q   <= div_dst_d;
        end
    end

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (op_a),
        .divisor  (op_b),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    assign instr_ready = (state_q == ST_IDLE);
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign flag_z      = flags_q[FLAG_Z];
    assign flag_c      = flags_q[FLAG_C];
    assign flag_dz     = flags_q[FLAG_DZ];
    assign dbg_data    = regs_q[dbg_sel];

endmodule

// File: doc/param_proc_core.md
Name: param_proc_core

Overview:
- Parametrised successor to the team's fixed 8-bit register/ALU processor.
- Holds NREGS registers of WIDTH bits and accepts one instruction per valid/ready handshake.
- Executes single-cycle ALU ops, or a multi-cycle iterative divide, and writes the result back to a destination register.
- Result and status flags are published to the surrounding test harness or SoC bus.

Parameters:
- WIDTH, 8: datapath and register width in bits; legal range 4..32.
- NREGS, 4: register file depth; power of two, minimum 2.
- SEL_W, $clog2(NREGS): width of the register select fields; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction present on the instr_* and imm_data inputs.
- instr_ready  out  1  core can accept an instruction this cycle.
- instr_op  in  4  opcode.
- instr_src  in  SEL_W  source register index (operand B).
- instr_dst  in  SEL_W  destination register index (operand A and write target).
- imm_data  in  WIDTH  immediate value for LDI.
- res_valid  out  1  one-cycle pulse: res_data and flags updated.
- res_data  out  WIDTH  last result written back.
- flag_z  out  1  last result equals zero.
- flag_c  out  1  carry/borrow/overflow/shifted-out bit of the last op.
- flag_dz  out  1  last DIV had a zero divisor.
- dbg_sel  in  SEL_W  debug read index.
- dbg_data  out  WIDTH  combinational read of reg[dbg_sel].

Behaviour:
- Reset (rst=1 at a clk edge):
  - All registers, res_data and flags cleared to 0.
  - res_valid=0, FSM forced to IDLE, instr_ready=1 in the next cycle.
  - An in-flight DIV is aborted with no writeback.
- Accept: an instruction is accepted at a clk edge when instr_valid && instr_ready. Inputs are don't-care otherwise.
- Operands: A=reg[instr_dst], B=reg[instr_src], both sampled at the accept edge.
- Opcodes:
  - 0 ADD A+B; c = carry out.
  - 1 SUB A-B; c = borrow.
  - 2 MUL: low WIDTH bits of A*B; c = 1 if the high half is nonzero.
  - 3 DIV: A/B, unsigned.
  - 4 NOT: ~A.
  - 5 AND, 6 OR, 7 XOR.
  - 8 SHL: B<<1; c = B[MSB].
  - 9 SHR: B>>1; c = B[0].
  - 10 ROR: B rotated right by 1; c = 0.
  - 11 ROL: B rotated left by 1; c = 0.
  - 12 LDI: result = imm_data.
  - 13 MOV: result = B.
  - 14 CLR: every register set to 0; result 0.
  - 15 NOP: no write, no res_valid, flags unchanged.
- Single-cycle ops (all except DIV and NOP):
  - reg[dst], res_data and flags are written on the accept edge.
  - res_valid=1 in the following cycle; latency 1.
  - instr_ready stays 1, giving throughput of one instruction per cycle.
- Back-to-back dependency: an instruction reading a register written by the previous instruction sees the new value. There is no hazard, because writeback happens at the accept edge.
- FSM states: IDLE and DIV_RUN.
  - IDLE -> DIV_RUN on an accepted DIV with B != 0: load the divider and set the counter to WIDTH. instr_ready=0 while in DIV_RUN.
  - DIV_RUN: one restoring-division step per cycle; counter decrements.
  - DIV_RUN -> IDLE after exactly WIDTH steps: write the quotient to reg[dst] on that edge; res_valid=1 the next cycle.
  - DIV total latency from accept to res_valid is WIDTH+1 cycles.
- DIV flags: on completion c=0 and dz=0.
- DIV by zero: no DIV_RUN.
  - Result = all ones, dz=1, c=0, written on the accept edge.
  - Latency 1, same as single-cycle ops.
- flag_dz is cleared by any other completed op except NOP.
- flag_z reflects res_data after every completed op.
- All arithmetic is unsigned and wraps modulo 2^WIDTH.
- src == dst is legal; both operands read the same pre-write value.

Optional Feature:
- Macro: PROC_CORE_ROTN_EN.
- Defined:
  - Opcodes 10/11 rotate B by A[$clog2(WIDTH)-1:0] positions instead of 1.
  - c = last bit rotated across the MSB/LSB boundary.
  - Rotate amount 0 gives result=B and c=0.
- Undefined: rotate-by-1 behaviour exactly as listed under Behaviour.

Decomposition:
- Package param_proc_pkg holds:
  - the opcode localparams/enum (OP_ADD..OP_NOP);
  - the FSM state enum (ST_IDLE, ST_DIV_RUN);
  - the flag index constants.
- Sub-module seq_divider (WIDTH-parametrised, start/busy/done, quotient out) holds the restoring-divide iteration and counter.
- The core instantiates seq_divider; the ALU case statement and register file stay inline in the core.

Test Plan (WIDTH=8, NREGS=4):
- Reset, then set dbg_sel to each of 0..3 -> dbg_data=0 for every register, instr_ready=1, res_valid=0.
- LDI r1=200, LDI r2=100, ADD dst=1 src=2 -> res_data=44, flag_c=1; res_valid pulses 1 cycle after each accept; three instructions complete in three consecutive cycles.
- LDI r1=200, LDI r2=7, DIV dst=1 src=2 -> instr_ready low for 8 cycles, res_data=28, dbg_data(r1)=28, res_valid exactly 9 cycles after accept.
- DIV with r2=0 -> res_data=255, flag_dz=1, latency 1; a following ADD clears flag_dz.
- Assert rst 3 cycles into a DIV -> no res_valid, r1 reads 0, instr_ready=1 in the next cycle.
- SUB r0=5 minus r3=6 -> res_data=255, flag_c=1, flag_z=0; then CLR -> all registers 0, flag_z=1.
